// File: rtl/geofence_feeder.sv
// Host-side feeder for the geofence detector: fetches 7-point sets from point RAM,
// streams them on X/Y with fixed timing, and records the detector results.
module geofence_feeder #(
  parameter int unsigned SET_W   = 8,
  parameter int unsigned AW      = 11,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SET_W-1:0] num_sets,
  output logic             mem_rd,
  output logic [AW-1:0]    mem_addr,
  input  logic [19:0]      mem_rdata,
  output logic [9:0]       X,
  output logic [9:0]       Y,
  input  logic             valid,
  input  logic             is_inside,
  output logic             res_we,
  output logic [SET_W-1:0] res_addr,
  output logic             res_data,
  output logic [SET_W-1:0] inside_cnt,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err
);

  localparam int unsigned PT_W = 20;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SEND, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SET_W-1:0] num_q, num_d;
  logic [SET_W-1:0] set_idx_q, set_idx_d;
  logic [AW-1:0]    base_q, base_d;
  logic             mem_rd_q, mem_rd_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [2:0]       iss_k_q, iss_k_d;
  logic             wr_en_q, wr_en_d;
  logic [2:0]       wr_k_q, wr_k_d;
  logic             fill_done_q, fill_done_d;
  logic [2:0]       send_k_q, send_k_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [PT_W-1:0]  xy_q, xy_d;
  logic             res_we_q, res_we_d;
  logic [SET_W-1:0] res_addr_q, res_addr_d;
  logic             res_data_q, res_data_d;
  logic [SET_W-1:0] inside_q, inside_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             more_c;

  logic [PT_W-1:0]  pbuf_q [0:6];

  assign more_c = ({1'b0, set_idx_q} + (SET_W+1)'(1)) < {1'b0, num_q};

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    set_idx_d   = set_idx_q;
    base_d      = base_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    iss_k_d     = iss_k_q;
    wr_en_d     = mem_rd_q;
    wr_k_d      = iss_k_q;
    fill_done_d = fill_done_q;
    send_k_d    = send_k_q;
    to_cnt_d    = to_cnt_q;
    xy_d        = xy_q;
    res_we_d    = 1'b0;
    res_addr_d  = res_addr_q;
    res_data_d  = res_data_q;
    inside_d    = inside_q;
    done_d      = done_q;
    err_d       = err_q;

    // Read issue engine; the fill flag rises the edge after the last read cycle.
    if (mem_rd_q) begin
      if (iss_k_q == 3'd6) begin
        mem_rd_d    = 1'b0;
        fill_done_d = 1'b1;
      end else begin
        iss_k_d    = iss_k_q + 3'd1;
        mem_addr_d = mem_addr_q + AW'(1);
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d     = num_sets;
          set_idx_d = '0;
          base_d    = '0;
          err_d     = 2'b00;
          inside_d  = '0;
          done_d    = 1'b0;
          if (num_sets == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_FILL;
            mem_rd_d    = 1'b1;
            mem_addr_d  = '0;
            iss_k_d     = 3'd0;
            fill_done_d = 1'b0;
          end
        end else if (state_q == S_DONE) begin
          done_d = 1'b1;
        end
      end
      S_FILL: begin
        if (fill_done_q) begin
          state_d  = S_SEND;
          xy_d     = pbuf_q[0];
          send_k_d = 3'd1;
        end
      end
      S_SEND: begin
        if (send_k_q == 3'd7) begin
          xy_d     = '0;
          state_d  = S_WAIT;
          to_cnt_d = TO_W'(1);
          if (more_c) begin
            mem_rd_d    = 1'b1;
            mem_addr_d  = base_q + AW'(7);
            iss_k_d     = 3'd0;
            fill_done_d = 1'b0;
          end
        end else begin
          xy_d     = pbuf_q[send_k_q];
          send_k_d = send_k_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (valid) begin
          res_we_d   = 1'b1;
          res_addr_d = set_idx_q;
          res_data_d = is_inside;
          if (is_inside && (inside_q != {SET_W{1'b1}})) inside_d = inside_q + SET_W'(1);
          if (!more_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (fill_done_q) begin
            set_idx_d = set_idx_q + SET_W'(1);
            base_d    = base_q + AW'(7);
            state_d   = S_SEND;
            xy_d      = pbuf_q[0];
            send_k_d  = 3'd1;
          end else begin
            err_d[1] = 1'b1;
            mem_rd_d = 1'b0;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end
        end else if (to_cnt_q >= TO_W'(TIMEOUT - 1)) begin
          err_d[0] = 1'b1;
          mem_rd_d = 1'b0;
          state_d  = S_DONE;
          done_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_FILL) || (state_d == S_SEND) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      set_idx_q   <= '0;
      base_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      iss_k_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_k_q      <= '0;
      fill_done_q <= 1'b0;
      send_k_q    <= '0;
      to_cnt_q    <= '0;
      xy_q        <= '0;
      res_we_q    <= 1'b0;
      res_addr_q  <= '0;
      res_data_q  <= 1'b0;
      inside_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      set_idx_q   <= set_idx_d;
      base_q      <= base_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      iss_k_q     <= iss_k_d;
      wr_en_q     <= wr_en_d;
      wr_k_q      <= wr_k_d;
      fill_done_q <= fill_done_d;
      send_k_q    <= send_k_d;
      to_cnt_q    <= to_cnt_d;
      xy_q        <= xy_d;
      res_we_q    <= res_we_d;
      res_addr_q  <= res_addr_d;
      res_data_q  <= res_data_d;
      inside_q    <= inside_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Point buffer: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_q) pbuf_q[wr_k_q] <= mem_rdata;
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign X          = xy_q[19:10];
  assign Y          = xy_q[9:0];
  assign res_we     = res_we_q;
  assign res_addr   = res_addr_q;
  assign res_data   = res_data_q;
  assign inside_cnt = inside_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_geofence_feeder.sv
// Directed bench for geofence_feeder: point RAM model, timed detector valid strobes,
// and cycle-exact checks of the X/Y stream, results, errors and reset behaviour.
module tb_geofence_feeder;

  localparam int unsigned SET_W = 8;
  localparam int unsigned AW    = 11;
  localparam int unsigned TO    = 16;
  localparam int unsigned TO_W  = 8;

  logic             clk;
  logic             reset;
  logic             start;
  logic [SET_W-1:0] num_sets;
  logic             mem_rd;
  logic [AW-1:0]    mem_addr;
  logic [19:0]      mem_rdata;
  logic [9:0]       X;
  logic [9:0]       Y;
  logic             valid;
  logic             is_inside;
  logic             res_we;
  logic [SET_W-1:0] res_addr;
  logic             res_data;
  logic [SET_W-1:0] inside_cnt;
  logic             busy;
  logic             done;
  logic [1:0]       err;

  int n_cmp = 0;
  int n_mis = 0;
  int n_we  = 0;
  int n_rd  = 0;
  int addr_log[$];
  logic [19:0] mem [0:63];

  geofence_feeder #(.SET_W(SET_W), .AW(AW), .TIMEOUT(TO), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_sets(num_sets),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .X(X), .Y(Y), .valid(valid), .is_inside(is_inside),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .inside_cnt(inside_cnt), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Point RAM: one-cycle read latency.
  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[5:0]];

  always @(negedge clk) begin
    if (mem_rd) begin
      addr_log.push_back(int'(mem_addr));
      n_rd++;
    end
    if (res_we) n_we++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pt(input int x, input int y);
    return {10'(x), 10'(y)};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the negedge of cycle S.
  task automatic do_start(input int n);
    start    = 1'b1;
    num_sets = SET_W'(n);
    addr_log.delete();
    n_we = 0;
    n_rd = 0;
    step(1);
    start = 1'b0;
  endtask

  // Checks points 0..6 of set s on consecutive cycles, then the idle cycle L+1.
  task automatic stream_check(input int s);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("xy_s%0d_p%0d", s, k), 32'({X, Y}), 32'(mem[7*s+k]));
      step(1);
    end
    check($sformatf("xy_s%0d_idle", s), 32'({X, Y}), 0);
  endtask

  // Detector strobe sampled at the edge after `pre` more cycles; ends in cycle P.
  task automatic pulse_valid(input int pre, input logic ins);
    step(pre);
    valid     = 1'b1;
    is_inside = ins;
    step(1);
    valid     = 1'b0;
    is_inside = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_sets = '0; valid = 1'b0; is_inside = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    // Set targets: (5,5) inside, (20,20) outside, (3,7) inside the 10x10 square.
    mem[0] = pt(5, 5); mem[7] = pt(20, 20); mem[14] = pt(3, 7);
    for (int s = 0; s < 3; s++) begin
      mem[7*s+1] = pt(0, 0);   mem[7*s+2] = pt(5, 0);  mem[7*s+3] = pt(10, 0);
      mem[7*s+4] = pt(10, 10); mem[7*s+5] = pt(0, 10); mem[7*s+6] = pt(0, 5);
    end

    step(2);
    check("rst_ctrl", 32'({mem_rd, res_we, busy, done, err, res_data}), 0);
    check("rst_xy", 32'({X, Y}), 0);
    check("rst_cnt", 32'({mem_addr, res_addr, inside_cnt}), 0);
    reset = 1'b0;
    step(2);

    // One set, inside.
    do_start(1);
    check("t1_rd_s", 32'(mem_rd), 1);
    check("t1_addr_s", 32'(mem_addr), 0);
    check("t1_busy", 32'(busy), 1);
    step(6);
    check("t1_addr_s6", 32'(mem_addr), 6);
    step(1);
    check("t1_rd_s7", 32'(mem_rd), 0);
    step(1);
    stream_check(0);
    pulse_valid(9, 1'b1);
    check("t1_we", 32'(res_we), 1);
    check("t1_res_addr", 32'(res_addr), 0);
    check("t1_res_data", 32'(res_data), 1);
    check("t1_inside_cnt", 32'(inside_cnt), 1);
    check("t1_done", 32'(done), 1);
    check("t1_err", 32'(err), 0);
    check("t1_busy_end", 32'(busy), 0);
    step(1);
    check("t1_we_count", n_we, 1);

    // Three sets, results 1,0,1, valid at L+11 each time.
    do_start(3);
    step(8);
    stream_check(0);
    pulse_valid(9, 1'b1);
    check("t2_res0_addr", 32'(res_addr), 0);
    check("t2_res0_data", 32'(res_data), 1);
    stream_check(1);
    pulse_valid(9, 1'b0);
    check("t2_res1_addr", 32'(res_addr), 1);
    check("t2_res1_data", 32'(res_data), 0);
    check("t2_busy_mid", 32'(busy), 1);
    stream_check(2);
    pulse_valid(9, 1'b1);
    check("t2_res2_addr", 32'(res_addr), 2);
    check("t2_res2_data", 32'(res_data), 1);
    check("t2_done", 32'(done), 1);
    check("t2_inside_cnt", 32'(inside_cnt), 2);
    step(1);
    check("t2_we_count", n_we, 3);
    check("t2_addr_count", addr_log.size(), 21);
    for (int i = 0; i < addr_log.size(); i++) check($sformatf("t2_addr%0d", i), addr_log[i], i);

    // Late fill: valid at L+6 while set 1 is still being fetched.
    do_start(2);
    step(8);
    stream_check(0);
    pulse_valid(4, 1'b1);
    check("t3_err", 32'(err), 2);
    check("t3_done", 32'(done), 1);
    check("t3_rd", 32'(mem_rd), 0);
    check("t3_we", 32'(res_we), 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("t3_quiet", 32'({mem_rd, X, Y}), 0);
    end
    check("t3_err_sticky", 32'(err), 2);

    // Timeout: no valid at all.
    do_start(1);
    step(8);
    stream_check(0);
    step(14);
    check("t4_err_l15", 32'(err), 0);
    check("t4_busy_l15", 32'(busy), 1);
    step(1);
    check("t4_err_l16", 32'(err), 1);
    check("t4_done_l16", 32'(done), 1);
    check("t4_xy", 32'({X, Y}), 0);
    step(3);
    check("t4_no_we", n_we, 0);

    // Zero sets.
    do_start(0);
    check("t5_done_s", 32'(done), 0);
    check("t5_busy_s", 32'(busy), 0);
    step(1);
    check("t5_done_s1", 32'(done), 1);
    step(3);
    check("t5_no_rd", n_rd, 0);
    check("t5_xy", 32'({X, Y}), 0);

    // Reset during point 3, then a clean rerun with a start pulse in WAIT.
    do_start(1);
    step(11);
    check("t6_pt3", 32'({X, Y}), 32'(mem[3]));
    #2 reset = 1'b1;
    #1;
    check("t6_rst_xy", 32'({X, Y}), 0);
    check("t6_rst_ctrl", 32'({mem_rd, res_we, busy, done, err}), 0);
    step(1);
    reset = 1'b0;
    step(1);
    do_start(2);
    step(8);
    stream_check(0);
    start = 1'b1; num_sets = SET_W'(5);
    step(1);
    start = 1'b0;
    pulse_valid(8, 1'b1);
    check("t6_res0_addr", 32'(res_addr), 0);
    check("t6_busy", 32'(busy), 1);
    stream_check(1);
    pulse_valid(9, 1'b0);
    check("t6_res1_addr", 32'(res_addr), 1);
    check("t6_done", 32'(done), 1);
    check("t6_inside_cnt", 32'(inside_cnt), 1);
    check("t6_err", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
